branch_resolve_unit: RTL and testbench

- Execute-stage consumer of the branch comparator's BrEQ/BrLT flags.
- Decodes funct3 to produce BrUn for the comparator, resolves the actual branch outcome, and checks it against the fetch-time prediction.
- Issues a registered redirect/flush on misprediction.
- Owns a small 2-bit-counter branch history table (BHT), updated at resolution, with a read port for fetch, plus branch and mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 127 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolution, redirect, 2-bit BHT and statistics
module branch_resolve_unit #(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES),
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_stall,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    output logic             BrUn,
    input  logic             BrEQ,
    input  logic             BrLT,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    logic [1:0]       bht [BHT_ENTRIES];
    logic             shadow;
    logic             taken;
    logic             legal;
    logic             resolve;
    logic             legal_resolve;
    logic             mispredict;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Only the word-aligned index bits of either PC address the table.
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[1:0]};

    // Fetch prediction is the counter MSB; no bypass of a same-cycle update.
    assign if_pred_taken = bht[if_idx][1];

    // Comparator mode depends on funct3 alone: BLTU/BGEU compare unsigned.
    assign BrUn = (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);

    // Decode the actual outcome; 010/011 are not branches and never act.
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            3'b000:          taken = BrEQ;
            3'b001:          taken = ~BrEQ;
            3'b100, 3'b110:  taken = BrLT;
            3'b101, 3'b111:  taken = ~BrLT;
            default: begin
                taken = 1'b0;
                legal = 1'b0;
            end
        endcase
    end

    // The cycle after a redirect carries a wrong-path instruction, so it is ignored.
    assign resolve       = ex_valid & ex_is_branch & ~ex_stall & ~shadow;
    assign legal_resolve = resolve & legal;
    assign mispredict    = legal_resolve & (taken != ex_pred_taken);

    // Registered redirect pulse and corrected PC; the PC holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= 32'h0;
            shadow         <= 1'b0;
        end else begin
            redirect_valid <= mispredict;
            flush          <= mispredict;
            shadow         <= mispredict;
            if (mispredict) begin
                redirect_pc <= taken ? ex_target : (ex_pc + 32'd4);
            end
        end
    end

    // Saturating 2-bit counters trained by every legal resolved branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (legal_resolve) begin
            if (taken) begin
                if (bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
                end
            end else begin
                if (bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
                end
            end
        end
    end

    // Wrapping statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (stat_clr) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (legal_resolve) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mispredict) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and random checks of branch_resolve_unit against a reference model
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic        if_pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic        ex_stall = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [31:0] ex_pc = 32'h0;
    logic [31:0] ex_target = 32'h0;
    logic        ex_pred_taken = 1'b0;
    logic        BrUn;
    logic        BrEQ = 1'b0;
    logic        BrLT = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        stat_clr = 1'b0;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state: counters as plain integers 0..3, one expected value per output.
    int          m_bht [16];
    bit          m_prev_mis;
    bit          m_rv;
    logic [31:0] m_rpc;
    longint      m_br;
    longint      m_mis;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_stall(ex_stall),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .BrUn(BrUn), .BrEQ(BrEQ), .BrLT(BrLT),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .stat_clr(stat_clr), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_prev_mis = 0;
        m_rv = 0;
        m_rpc = 32'h0;
        m_br = 0;
        m_mis = 0;
    endtask

    function automatic int tbl(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        bit is_legal, act, res, mis;
        int f;
        #1;
        f = int'(ex_funct3);
        chk("BrUn", BrUn, (f == 6 || f == 7));
        chk("if_pred_taken", if_pred_taken, (m_bht[tbl(if_pc)] >= 2));
        is_legal = !(f == 2 || f == 3);
        if (f == 0)                 act = BrEQ;
        else if (f == 1)            act = !BrEQ;
        else if (f == 4 || f == 6)  act = BrLT;
        else if (f == 5 || f == 7)  act = !BrLT;
        else                        act = 0;
        res = ex_valid && ex_is_branch && !ex_stall && !m_prev_mis && is_legal;
        mis = res && (act != ex_pred_taken);
        @(posedge clk);
        if (mis) m_rpc = act ? ex_target : ex_pc + 32'd4;
        m_rv = mis;
        m_prev_mis = mis;
        if (res) m_bht[tbl(ex_pc)] = act ? ((m_bht[tbl(ex_pc)] < 3) ? m_bht[tbl(ex_pc)] + 1 : 3)
                                         : ((m_bht[tbl(ex_pc)] > 0) ? m_bht[tbl(ex_pc)] - 1 : 0);
        if (stat_clr) begin
            m_br = 0;
            m_mis = 0;
        end else begin
            m_br  = (m_br + (res ? 1 : 0)) % 64'h1_0000_0000;
            m_mis = (m_mis + (mis ? 1 : 0)) % 64'h1_0000_0000;
        end
        #1;
        chk("redirect_valid", redirect_valid, m_rv);
        chk("flush", flush, m_rv);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("br_count", br_count, m_br[31:0]);
        chk("mispred_count", mispred_count, m_mis[31:0]);
        @(negedge clk);
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pred, input logic eq, input logic lt);
        ex_valid = 1; ex_is_branch = 1; ex_stall = 0;
        ex_funct3 = f3; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
        BrEQ = eq; BrLT = lt;
        cycle();
    endtask

    task automatic idle();
        ex_valid = 0; ex_is_branch = 0; ex_stall = 0;
        cycle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset redirect_valid", redirect_valid, 1'b0);
        chk("reset redirect_pc", redirect_pc, 32'h0);
        chk("reset br_count", br_count, 32'h0);
        rst_n = 1;

        // Plan 1: BEQ taken but predicted not-taken
        if_pc = 32'h100;
        br(3'b000, 32'h100, 32'h80, 0, 1, 0);
        chk("plan1 redirect_pc", redirect_pc, 32'h80);
        chk("plan1 mispred_count", mispred_count, 32'd1);
        idle();
        chk("plan1 counter0 now taken", if_pred_taken, 1'b1);

        // Plan 2: BLT correctly predicted taken, counter saturates
        if_pc = 32'h104;
        repeat (3) br(3'b100, 32'h104, 32'h200, 1, 0, 1);
        br(3'b100, 32'h104, 32'h200, 1, 0, 1);
        chk("plan2 no redirect", redirect_valid, 1'b0);

        // Plan 3: BrUn for BGEU, then wrap of pc+4
        ex_funct3 = 3'b111; #1;
        chk("plan3 BrUn unsigned", BrUn, 1'b1);
        br(3'b001, 32'hFFFF_FFFC, 32'h40, 1, 1, 0);
        chk("plan3 redirect wrap", redirect_pc, 32'h0);

        // Plan 4: branch in the shadow cycle is ignored, N+2 resolves
        br(3'b000, 32'h10, 32'h20, 1, 0, 0);
        br(3'b000, 32'h10, 32'h20, 1, 0, 0);
        br(3'b000, 32'h14, 32'h20, 0, 0, 0);

        // Plan 5: stalled branch resolves once; illegal funct3 does nothing
        ex_stall = 1;
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b101; ex_pc = 32'h18;
        ex_pred_taken = 0; BrLT = 0;
        repeat (3) cycle();
        br(3'b101, 32'h18, 32'h30, 0, 0, 0);
        br(3'b010, 32'h1C, 32'h30, 1, 1, 1);
        br(3'b011, 32'h1C, 32'h30, 1, 1, 1);

        // Plan 6: clear beats a mispredict increment; reset drops the pulse
        stat_clr = 1;
        br(3'b000, 32'h100, 32'h300, 0, 1, 0);
        stat_clr = 0;
        chk("plan6 cleared br_count", br_count, 32'h0);
        chk("plan6 redirect issued", redirect_valid, 1'b1);
        rst_n = 0;
        #1;
        chk("plan6 async drop", redirect_valid, 1'b0);
        model_reset();
        if_pc = 32'h100; #1;
        chk("plan6 bht back to 01", if_pred_taken, 1'b0);
        @(negedge clk);
        rst_n = 1;

        // Random traffic concentrated on a few table entries
        for (int i = 0; i < 400; i++) begin
            ex_valid      = ($urandom_range(0, 9) != 0);
            ex_is_branch  = ($urandom_range(0, 7) != 0);
            ex_stall      = ($urandom_range(0, 4) == 0);
            ex_funct3     = 3'($urandom);
            ex_pc         = {$urandom_range(0, 3) == 0 ? 28'($urandom) : 28'h0, 4'h0}
                            | (32'($urandom_range(0, 3)) << 2);
            ex_target     = $urandom;
            ex_pred_taken = 1'($urandom);
            BrEQ          = 1'($urandom);
            BrLT          = 1'($urandom);
            if_pc         = 32'($urandom_range(0, 15)) << 2;
            stat_clr      = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
